// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one pulse-protocol memory bus between the fetch port (F) and the
//   mem-stage port (M). Each port has a one-entry pending slot; grants are
//   round-robin, one transaction is in flight at a time, and the response is
//   routed back to the owner. A watchdog ends transactions that never get a
//   bus response and reports the expiry on a sticky error flag.
//
// Ports
//   clk, rst                         clock (posedge) / synchronous active-high reset
//   f_request_enable .. f_wstrb      fetch request pulse and its payload
//   f_response_enable, f_data        fetch response pulse and data
//   m_request_enable .. m_data       same set for the mem stage
//   bus_request_enable .. bus_wstrb  downstream request pulse and payload
//   bus_response_enable, bus_data    downstream response pulse and data
//   grant_id                         owner of the in-flight transaction (0=F, 1=M)
//   busy                             high while a transaction is in flight
//   timeout_error                    sticky watchdog-expiry flag, cleared by rst
//
// Mode encoding: 0 = read, 1 = write.

module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_request_enable,
   input  logic        f_mode,
   input  logic [31:0] f_addr,
   input  logic [31:0] f_wdata,
   input  logic [3:0]  f_wstrb,
   output logic        f_response_enable,
   output logic [31:0] f_data,
   input  logic        m_request_enable,
   input  logic        m_mode,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_wstrb,
   output logic        m_response_enable,
   output logic [31:0] m_data,
   output logic        bus_request_enable,
   output logic        bus_mode,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_response_enable,
   input  logic [31:0] bus_data,
   output logic        grant_id,
   output logic        busy,
   output logic        timeout_error
);

   typedef struct packed {
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam bit          WDOG_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        f_pend_q, f_pend_d;
   logic        m_pend_q, m_pend_d;
   req_t        f_slot_q, f_slot_d;
   req_t        m_slot_q, m_slot_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   req_t        bus_q, bus_d;
   logic        f_resp_q, f_resp_d;
   logic [31:0] f_data_q, f_data_d;
   logic        m_resp_q, m_resp_d;
   logic [31:0] m_data_q, m_data_d;
   logic        tmo_q, tmo_d;

   logic        sel_m;
   logic [15:0] cnt_inc;
   logic        done;
   logic [31:0] done_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         f_pend_q     <= 1'b0;
         m_pend_q     <= 1'b0;
         f_slot_q     <= '0;
         m_slot_q     <= '0;
         last_grant_q <= 1'b0;
         cnt_q        <= '0;
         bus_req_q    <= 1'b0;
         bus_q        <= '0;
         f_resp_q     <= 1'b0;
         f_data_q     <= '0;
         m_resp_q     <= 1'b0;
         m_data_q     <= '0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         f_pend_q     <= f_pend_d;
         m_pend_q     <= m_pend_d;
         f_slot_q     <= f_slot_d;
         m_slot_q     <= m_slot_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         bus_req_q    <= bus_req_d;
         bus_q        <= bus_d;
         f_resp_q     <= f_resp_d;
         f_data_q     <= f_data_d;
         m_resp_q     <= m_resp_d;
         m_data_q     <= m_data_d;
         tmo_q        <= tmo_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      f_pend_d     = f_pend_q;
      m_pend_d     = m_pend_q;
      f_slot_d     = f_slot_q;
      m_slot_d     = m_slot_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      bus_req_d    = 1'b0;
      bus_d        = bus_q;
      f_resp_d     = 1'b0;
      f_data_d     = f_data_q;
      m_resp_d     = 1'b0;
      m_data_d     = m_data_q;
      tmo_d        = tmo_q;
      sel_m        = 1'b0;
      cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      done         = 1'b0;
      done_data    = '0;

      // A slot stays pending until its response is pulsed, so a request is
      // accepted exactly when the slot is empty; this also admits a new
      // request in the cycle the previous response pulse is visible.
      if (f_request_enable && !f_pend_q) begin
         f_pend_d = 1'b1;
         f_slot_d = '{mode: f_mode, addr: f_addr, wdata: f_wdata, wstrb: f_wstrb};
      end
      if (m_request_enable && !m_pend_q) begin
         m_pend_d = 1'b1;
         m_slot_d = '{mode: m_mode, addr: m_addr, wdata: m_wdata, wstrb: m_wstrb};
      end

      case (state_q)
         S_IDLE: begin
            if (f_pend_q || m_pend_q) begin
               // M wins when it is alone or when F was granted last.
               sel_m        = m_pend_q && (!f_pend_q || !last_grant_q);
               bus_d        = sel_m ? m_slot_q : f_slot_q;
               bus_req_d    = 1'b1;
               last_grant_d = sel_m;
               cnt_d        = '0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (bus_response_enable) begin
               done      = 1'b1;
               done_data = bus_data;
            end else if (WDOG_EN && (cnt_inc == TIMEOUT_LIM)) begin
               done      = 1'b1;
               done_data = TIMEOUT_DATA;
               tmo_d     = 1'b1;
            end
            if (done) begin
               if (last_grant_q) begin
                  m_data_d = done_data;
                  m_resp_d = 1'b1;
                  m_pend_d = 1'b0;
               end else begin
                  f_data_d = done_data;
                  f_resp_d = 1'b1;
                  f_pend_d = 1'b0;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign f_response_enable  = f_resp_q;
   assign f_data             = f_data_q;
   assign m_response_enable  = m_resp_q;
   assign m_data             = m_data_q;
   assign bus_request_enable = bus_req_q;
   assign bus_mode           = bus_q.mode;
   assign bus_addr           = bus_q.addr;
   assign bus_wdata          = bus_q.wdata;
   assign bus_wstrb          = bus_q.wstrb;
   assign grant_id           = last_grant_q;
   assign busy               = (state_q == S_WAIT);
   assign timeout_error      = tmo_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_request_enable, f_mode;
   logic [31:0] f_addr, f_wdata;
   logic [3:0]  f_wstrb;
   logic        f_response_enable;
   logic [31:0] f_data;
   logic        m_request_enable, m_mode;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_response_enable;
   logic [31:0] m_data;
   logic        bus_request_enable, bus_mode;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_response_enable;
   logic [31:0] bus_data;
   logic        grant_id, busy, timeout_error;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst),
      .f_request_enable(f_request_enable), .f_mode(f_mode), .f_addr(f_addr),
      .f_wdata(f_wdata), .f_wstrb(f_wstrb),
      .f_response_enable(f_response_enable), .f_data(f_data),
      .m_request_enable(m_request_enable), .m_mode(m_mode), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_response_enable(m_response_enable), .m_data(m_data),
      .bus_request_enable(bus_request_enable), .bus_mode(bus_mode),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_response_enable(bus_response_enable), .bus_data(bus_data),
      .grant_id(grant_id), .busy(busy), .timeout_error(timeout_error)
   );

   typedef struct {
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        grant;
      logic [31:0] rdata;
   } bus_exp_t;

   typedef struct {
      logic        port;
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      int          dly;
   } vec_t;

   bus_exp_t    exp_bus[$];
   logic [31:0] exp_f[$];
   logic [31:0] exp_m[$];

   int          n_total = 0;
   int          n_pass  = 0;
   int          cyc     = 0;
   int          bus_cyc = 0;
   int          f_cyc   = 0;
   int          m_cyc   = 0;
   logic [31:0] mdl_f   = '0;
   logic [31:0] mdl_m   = '0;
   bit          resp_on = 1'b1;
   bit          resp_armed = 1'b0;
   int          resp_delay = 1;
   int          resp_cnt = 0;
   logic [31:0] resp_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock: outputs are observed 1 ns after the edge, pulses from the
   // previous interval are dropped, and the bus responder may answer.
   task automatic cycle();
      bus_exp_t    e;
      logic [31:0] d;
      @(posedge clk);
      #1;
      cyc++;
      f_request_enable    = 1'b0;
      m_request_enable    = 1'b0;
      bus_response_enable = 1'b0;
      if (bus_request_enable) begin
         if (exp_bus.size() == 0) chk("bus_req_unexpected", 32'(bus_request_enable), 0);
         else begin
            e = exp_bus.pop_front();
            chk("bus_mode",  32'(bus_mode),  32'(e.mode));
            chk("bus_addr",  bus_addr,       e.addr);
            chk("bus_wdata", bus_wdata,      e.wdata);
            chk("bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
            chk("grant_id",  32'(grant_id),  32'(e.grant));
            chk("busy_wait", 32'(busy),      1);
            bus_cyc = cyc;
            if (resp_on) begin
               resp_armed = 1'b1;
               resp_cnt   = resp_delay;
               resp_data  = e.rdata;
            end
         end
      end
      if (f_response_enable) begin
         if (exp_f.size() == 0) chk("f_resp_unexpected", 32'(f_response_enable), 0);
         else begin
            d = exp_f.pop_front();
            chk("f_data", f_data, d);
            mdl_f = d;
            f_cyc = cyc;
         end
      end
      if (m_response_enable) begin
         if (exp_m.size() == 0) chk("m_resp_unexpected", 32'(m_response_enable), 0);
         else begin
            d = exp_m.pop_front();
            chk("m_data", m_data, d);
            mdl_m = d;
            m_cyc = cyc;
         end
      end
      if (resp_armed) begin
         if (resp_cnt == 0) begin
            bus_response_enable = 1'b1;
            bus_data            = resp_data;
            resp_armed          = 1'b0;
         end else resp_cnt--;
      end
   endtask

   task automatic drive_raw(input logic port, input logic mode, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
      if (port) begin
         m_request_enable = 1'b1; m_mode = mode; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
      end else begin
         f_request_enable = 1'b1; f_mode = mode; f_addr = addr; f_wdata = wdata; f_wstrb = wstrb;
      end
   endtask

   // Drives a request that will be served; expectations are queued in the
   // order the bench expects the grants.
   task automatic issue(input logic port, input logic mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rdata);
      bus_exp_t e;
      drive_raw(port, mode, addr, wdata, wstrb);
      e = '{mode: mode, addr: addr, wdata: wdata, wstrb: wstrb, grant: port, rdata: rdata};
      exp_bus.push_back(e);
      if (port) exp_m.push_back(rdata);
      else      exp_f.push_back(rdata);
   endtask

   task automatic wait_resp(input logic port, input int max_cyc);
      int  n   = 0;
      bit  got = 1'b0;
      while (!got && n < max_cyc) begin
         cycle();
         n++;
         if (port ? m_response_enable : f_response_enable) got = 1'b1;
      end
      if (!got) chk("resp_wait_expired", 32'(port ? m_response_enable : f_response_enable), 1);
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((exp_bus.size() + exp_f.size() + exp_m.size() != 0 || busy) && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("drain_left", 32'(exp_bus.size() + exp_f.size() + exp_m.size()), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      chk("rst_bus_req", 32'(bus_request_enable), 0);
      chk("rst_resp",    32'({f_response_enable, m_response_enable}), 0);
      chk("rst_data",    f_data | m_data, 0);
      chk("rst_bus_flds", bus_addr | bus_wdata | 32'({bus_mode, bus_wstrb}), 0);
      chk("rst_status",  32'({grant_id, busy, timeout_error}), 0);
      rst = 1'b0;
      exp_bus.delete(); exp_f.delete(); exp_m.delete();
      resp_armed = 1'b0;
      mdl_f = '0;
      mdl_m = '0;
   endtask

   vec_t vecs[5];
   int   t;

   initial begin
      vecs[0] = '{port: 1'b0, mode: 1'b0, addr: 32'h0000_1000, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h1234_5678, dly: 2};
      vecs[1] = '{port: 1'b1, mode: 1'b1, addr: 32'h0000_2004, wdata: 32'h0102_0304, wstrb: 4'h3, rdata: 32'h0000_0001, dly: 0};
      vecs[2] = '{port: 1'b1, mode: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, wstrb: 4'h0, rdata: 32'hCAFE_F00D, dly: 5};
      vecs[3] = '{port: 1'b0, mode: 1'b1, addr: 32'h0000_0000, wdata: 32'hFFFF_FFFF, wstrb: 4'hC, rdata: 32'h8000_0000, dly: 1};
      vecs[4] = '{port: 1'b0, mode: 1'b0, addr: 32'h0000_1040, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h5555_AAAA, dly: 6};

      rst = 1'b1;
      f_request_enable = 1'b0; f_mode = 1'b0; f_addr = '0; f_wdata = '0; f_wstrb = '0;
      m_request_enable = 1'b0; m_mode = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      bus_response_enable = 1'b0; bus_data = '0;

      do_reset();

      // Uncontended transactions with latency checks.
      for (int i = 0; i < 5; i++) begin
         resp_delay = vecs[i].dly;
         t = cyc;
         issue(vecs[i].port, vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].rdata);
         wait_resp(vecs[i].port, 30);
         chk("lat_req",  32'(bus_cyc - t), 2);
         chk("lat_resp", 32'((vecs[i].port ? m_cyc : f_cyc) - bus_cyc), 32'(vecs[i].dly + 1));
         chk("hold_f_data", f_data, mdl_f);
         chk("hold_m_data", m_data, mdl_m);
         cycle();
         chk("idle_after", 32'(busy), 0);
      end

      // Ties: M first after reset, F after M's response; after an M grant, F wins.
      do_reset();
      resp_delay = 1;
      issue(1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'h0, 32'hA000_0001);
      issue(1'b0, 1'b0, 32'h0000_B000, 32'h0, 4'h0, 32'hB000_0001);
      drain(40);
      chk("tie_f_after_m", 32'(bus_cyc - m_cyc), 1);
      issue(1'b1, 1'b0, 32'h0000_A100, 32'h0, 4'h0, 32'hA100_0001);
      drain(40);
      issue(1'b0, 1'b0, 32'h0000_B200, 32'h0, 4'h0, 32'hB200_0001);
      issue(1'b1, 1'b0, 32'h0000_A200, 32'h0, 4'h0, 32'hA200_0001);
      drain(40);

      // M write held while F is in flight, issued two cycles after F's bus response.
      resp_delay = 4;
      issue(1'b0, 1'b0, 32'h0000_1100, 32'h0, 4'h0, 32'h1100_0011);
      cycle();
      cycle();
      issue(1'b1, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'hF, 32'h0000_0000);
      drain(40);
      chk("held_m_issue", 32'(bus_cyc - f_cyc), 1);

      // Watchdog expiry, then a late bus response that must be ignored.
      chk("tmo_clear", 32'(timeout_error), 0);
      resp_on = 1'b0;
      issue(1'b0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'hDEAD_BEEF);
      wait_resp(1'b0, 40);
      chk("tmo_latency", 32'(f_cyc - bus_cyc), 8);
      chk("tmo_flag", 32'(timeout_error), 1);
      bus_response_enable = 1'b1;
      bus_data = 32'h0BAD_0BAD;
      for (int i = 0; i < 4; i++) cycle();
      chk("late_f_data", f_data, 32'hDEAD_BEEF);
      chk("late_m_data", m_data, mdl_m);
      chk("late_busy", 32'(busy), 0);
      chk("tmo_sticky", 32'(timeout_error), 1);

      // Reset while F is in flight and M is pending.
      issue(1'b0, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 32'h0);
      cycle();
      cycle();
      chk("pre_rst_busy", 32'(busy), 1);
      drive_raw(1'b1, 1'b1, 32'h0000_7000, 32'h1111_2222, 4'hF);
      cycle();
      rst = 1'b1;
      cycle();
      chk("mid_rst_outs", 32'({bus_request_enable, f_response_enable, m_response_enable,
                                grant_id, busy, timeout_error}), 0);
      chk("mid_rst_data", f_data | m_data | bus_addr | bus_wdata, 0);
      rst = 1'b0;
      exp_bus.delete(); exp_f.delete(); exp_m.delete();
      resp_armed = 1'b0;
      mdl_f = '0;
      mdl_m = '0;
      resp_on = 1'b1;
      for (int i = 0; i < 12; i++) cycle();
      resp_delay = 1;
      t = cyc;
      issue(1'b0, 1'b0, 32'h1234_0000, 32'h0, 4'h0, 32'h0F0F_0F0F);
      wait_resp(1'b0, 30);
      chk("post_rst_lat", 32'(bus_cyc - t), 2);

      // Re-pulses while pending / in flight are dropped; a pulse in the
      // response cycle is captured.
      resp_delay = 3;
      issue(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h4000_0004);
      cycle();
      drive_raw(1'b0, 1'b1, 32'h0000_4444, 32'h9999_9999, 4'hF);
      cycle();
      drive_raw(1'b0, 1'b1, 32'h0000_4888, 32'h8888_8888, 4'h1);
      wait_resp(1'b0, 30);
      t = cyc;
      issue(1'b0, 1'b1, 32'h0000_3000, 32'h3333_3333, 4'h6, 32'h3000_0003);
      wait_resp(1'b0, 30);
      chk("resp_cycle_capture_lat", 32'(bus_cyc - t), 2);
      drain(40);
      for (int i = 0; i < 4; i++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
